// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers writeback packets in order and retires one
// per cycle into the register file, scoreboard release and commit counters.
module wb_commit_queue #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned AREG_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_wen,
    input  logic [AREG_W-1:0] in_waddr,
    input  logic              commit_en,
    input  logic              flush,
    output logic              rf_wen,
    output logic [AREG_W-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              sb_clr,
    output logic [AREG_W-1:0] sb_addr,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc,
    output logic [63:0]       instret,
    output logic              empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0]   pc_mem_q    [DEPTH];
    logic [XLEN-1:0]   res_mem_q   [DEPTH];
    logic              wen_mem_q   [DEPTH];
    logic [AREG_W-1:0] waddr_mem_q [DEPTH];

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic              rf_wen_q, rf_wen_d;
    logic [AREG_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              sb_clr_q, sb_clr_d;
    logic [AREG_W-1:0] sb_addr_q, sb_addr_d;
    logic              cv_q, cv_d;
    logic [XLEN-1:0]   cpc_q, cpc_d;
    logic [63:0]       instret_q, instret_d;

    logic push;
    logic pop;
    logic head_writes;

    assign in_ready = (count_q < cnt_t'(DEPTH));
    assign empty    = (count_q == '0);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = ~empty & commit_en & ~flush;

    // x0 retires like any other instruction but must not touch RF or scoreboard
    assign head_writes = wen_mem_q[head_q] & (waddr_mem_q[head_q] != '0);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rf_wen_d   = 1'b0;
        sb_clr_d   = 1'b0;
        cv_d       = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        sb_addr_d  = sb_addr_q;
        cpc_d      = cpc_q;
        instret_d  = instret_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + ptr_t'(1);
            end
            if (pop) begin
                head_d     = head_q + ptr_t'(1);
                cv_d       = 1'b1;
                cpc_d      = pc_mem_q[head_q];
                rf_wen_d   = head_writes;
                rf_waddr_d = waddr_mem_q[head_q];
                rf_wdata_d = res_mem_q[head_q];
                sb_clr_d   = head_writes;
                sb_addr_d  = waddr_mem_q[head_q];
                instret_d  = instret_q + 64'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]    <= in_pc;
            res_mem_q[tail_q]   <= in_result;
            wen_mem_q[tail_q]   <= in_wen;
            waddr_mem_q[tail_q] <= in_waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sb_clr_q   <= 1'b0;
            sb_addr_q  <= '0;
            cv_q       <= 1'b0;
            cpc_q      <= '0;
            instret_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            sb_clr_q   <= sb_clr_d;
            sb_addr_q  <= sb_addr_d;
            cv_q       <= cv_d;
            cpc_q      <= cpc_d;
            instret_q  <= instret_d;
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign sb_clr       = sb_clr_q;
    assign sb_addr      = sb_addr_q;
    assign commit_valid = cv_q;
    assign commit_pc    = cpc_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: queue-based reference model, directed scenarios
// with literal expectations, then a randomized run.
module tb_wb_commit_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [63:0] in_result = '0;
    logic        in_wen = 1'b0;
    logic [4:0]  in_waddr = '0;
    logic        commit_en = 1'b0;
    logic        flush = 1'b0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        sb_clr;
    logic [4:0]  sb_addr;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] instret;
    logic        empty;

    wb_commit_queue #(.XLEN(64), .AREG_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_result(in_result),
        .in_wen(in_wen), .in_waddr(in_waddr),
        .commit_en(commit_en), .flush(flush),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_clr(sb_clr), .sb_addr(sb_addr),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .instret(instret), .empty(empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [63:0] res;
        logic        wen;
        logic [4:0]  wa;
    } pkt_t;

    pkt_t        mq[$];
    bit          m_started = 0;
    logic        m_cv, m_rfwen, m_sbclr;
    logic [4:0]  m_wa, m_sba;
    logic [63:0] m_wd, m_pc, m_instret;

    // Reference: a plain queue, updated from the inputs seen at each edge
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_started = 1;
            {m_cv, m_rfwen, m_sbclr} = '0;
            m_wa = '0; m_sba = '0; m_wd = '0; m_pc = '0; m_instret = '0;
        end else if (m_started) begin
            m_cv = 0; m_rfwen = 0; m_sbclr = 0;
            if (flush) begin
                mq.delete();
            end else begin
                bit do_push;
                do_push = in_valid && (mq.size() < DEPTH);
                if (commit_en && mq.size() > 0) begin
                    pkt_t p;
                    p = mq.pop_front();
                    m_cv = 1;
                    m_pc = p.pc;
                    m_rfwen = p.wen && (p.wa != 0);
                    m_sbclr = m_rfwen;
                    m_wa = p.wa;
                    m_sba = p.wa;
                    m_wd = p.res;
                    m_instret = m_instret + 1;
                end
                if (do_push)
                    mq.push_back('{in_pc, in_result, in_wen, in_waddr});
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("commit_valid", 64'(commit_valid), 64'(m_cv));
            chk("rf_wen", 64'(rf_wen), 64'(m_rfwen));
            chk("sb_clr", 64'(sb_clr), 64'(m_sbclr));
            chk("rf_waddr", 64'(rf_waddr), 64'(m_wa));
            chk("sb_addr", 64'(sb_addr), 64'(m_sba));
            chk("rf_wdata", rf_wdata, m_wd);
            chk("commit_pc", commit_pc, m_pc);
            chk("instret", instret, m_instret);
            chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("empty", 64'(empty), 64'(mq.size() == 0));
        end
    end

    task automatic drive(input logic v, input logic [63:0] pc,
                         input logic [63:0] res, input logic w,
                         input logic [4:0] wa);
        in_valid = v; in_pc = pc; in_result = res; in_wen = w; in_waddr = wa;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic ready_seen[5];

        step(); step();
        reset = 0;
        step();
        chk("lit_rst_empty", 64'(empty), 64'd1);
        chk("lit_rst_ready", 64'(in_ready), 64'd1);
        chk("lit_rst_instret", instret, 64'd0);

        // single packet: accepted N, visible N+2
        commit_en = 1;
        drive(1, 64'h8000_0000, 64'h1234, 1, 5'd5);
        step();
        drive(0, '0, '0, 0, '0);
        step();
        chk("lit_single_rfwen", 64'(rf_wen), 64'd1);
        chk("lit_single_waddr", 64'(rf_waddr), 64'd5);
        chk("lit_single_wdata", rf_wdata, 64'h1234);
        chk("lit_single_sbclr", 64'(sb_clr), 64'd1);
        chk("lit_single_pc", commit_pc, 64'h8000_0000);
        chk("lit_single_instret", instret, 64'd1);

        // x0 write retires silently
        drive(1, 64'h8000_0004, 64'hdead, 1, 5'd0);
        step();
        drive(0, '0, '0, 0, '0);
        step();
        chk("lit_x0_cv", 64'(commit_valid), 64'd1);
        chk("lit_x0_rfwen", 64'(rf_wen), 64'd0);
        chk("lit_x0_sbclr", 64'(sb_clr), 64'd0);
        chk("lit_x0_instret", instret, 64'd2);

        // fill while held, fifth push refused
        commit_en = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 64'h100 + 64'(i * 4), 64'(i), 1, 5'(i + 1));
            ready_seen[i] = in_ready;
            step();
        end
        for (int i = 0; i < 5; i++)
            chk("lit_full_ready", 64'(ready_seen[i]), 64'(i < 4));
        drive(0, '0, '0, 0, '0);
        commit_en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lit_drain_pc", commit_pc, 64'h100 + 64'(i * 4));
            chk("lit_drain_cv", 64'(commit_valid), 64'd1);
            if (i == 0) chk("lit_drain_ready", 64'(in_ready), 64'd1);
        end
        step();
        chk("lit_drain_instret", instret, 64'd6);

        // streaming push/pop wraps pointers
        for (int i = 0; i < 10; i++) begin
            drive(1, 64'h200 + 64'(i * 4), 64'(i * 7), 1, 5'(i + 3));
            step();
        end
        drive(0, '0, '0, 0, '0);
        step();
        chk("lit_stream_instret", instret, 64'd16);

        // flush with three buffered and a push in flight
        commit_en = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h300 + 64'(i * 4), 64'hf0, 1, 5'd9);
            step();
        end
        flush = 1;
        step();
        flush = 0;
        drive(0, '0, '0, 0, '0);
        chk("lit_flush_empty", 64'(empty), 64'd1);
        commit_en = 1;
        step(); step();
        chk("lit_flush_cv", 64'(commit_valid), 64'd0);
        chk("lit_flush_instret", instret, 64'd16);

        // reset with two queued
        commit_en = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 64'h400 + 64'(i * 4), 64'h77, 1, 5'd4);
            step();
        end
        drive(0, '0, '0, 0, '0);
        reset = 1;
        step();
        reset = 0;
        chk("lit_rst2_instret", instret, 64'd0);
        chk("lit_rst2_empty", 64'(empty), 64'd1);
        chk("lit_rst2_ready", 64'(in_ready), 64'd1);
        chk("lit_rst2_pc", commit_pc, 64'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 99) < 65, {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom));
            commit_en = $urandom_range(0, 99) < 60;
            flush = $urandom_range(0, 99) < 3;
            reset = $urandom_range(0, 499) == 0;
            step();
        end
        drive(0, '0, '0, 0, '0);
        flush = 0; reset = 0; commit_en = 1;
        for (int i = 0; i < 8; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
